// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
package fifo_stream_reader_pkg;

  // IDLE: no pops issued; RUN: draining the FIFO; ERR: sticky fault, pops blocked.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Below two entries the buffer cannot hold the word landing from an in-flight pop.
  localparam int MIN_BUF_DEPTH = 2;

  // Occupancy counts 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Circular skid buffer absorbing the FIFO read latency; head entry drives the stream.
module fifo_stream_reader_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  generate
    if (DEPTH < MIN_BUF_DEPTH) begin : g_depth_too_small
      $error("fifo_stream_reader_buf: DEPTH must be at least MIN_BUF_DEPTH");
    end
  endgenerate

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; entries clear on reset so the idle head reads zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head];

  // The issue credit check keeps a landing word from ever meeting a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (occ == OCC_W'(DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync FIFO onto a valid/ready stream with a small skid buffer.
//
// state | meaning
// IDLE  | no pops issued, waiting for rd_en
// RUN   | pops issued while FIFO non-empty and buffer credit remains
// ERR   | FIFO or protocol fault seen; pops blocked, buffer drains, until reset
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BUF_DEPTH   = 3,
  parameter bit SINGLE_PORT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_en,
  input  logic             fifo_wr_req,
  input  logic             fifo_mt,
  input  logic             fifo_err,
  input  logic             fifo_rd_vld,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic             busy,
  output logic             err
);

  localparam int OCC_W = occ_width(BUF_DEPTH);
  localparam int SUM_W = OCC_W + 1;

  state_t           state;
  logic             inflight;
  logic             err_q;
  logic [OCC_W-1:0] occ;
  logic [SUM_W-1:0] credit_sum;
  logic             credit_ok;
  logic             wr_block;
  logic             mismatch;
  logic             capture;
  logic             consume;

  // Credit uses only registered occupancy, so out_rdy never reaches fifo_rd.
  assign credit_sum = SUM_W'(occ) + SUM_W'(inflight);
  assign credit_ok  = credit_sum < SUM_W'(BUF_DEPTH);
  assign wr_block   = SINGLE_PORT ? fifo_wr_req : 1'b0;

  assign fifo_rd = (state == RUN) & rd_en & ~fifo_mt & ~wr_block & credit_ok;

  // Read-data valid must track our own pop one cycle later; anything else is a fault.
  assign mismatch = fifo_rd_vld ^ inflight;
  assign capture  = inflight & fifo_rd_vld;

  assign out_vld = (occ != '0);
  assign consume = out_vld & out_rdy;
  assign busy    = inflight | out_vld;
  assign err     = err_q;

  // Sequencing FSM, pop tracking and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (fifo_err || mismatch) begin
        state <= ERR;
        err_q <= 1'b1;
      end else begin
        case (state)
          IDLE:    if (rd_en) state <= RUN;
          RUN:     if (!rd_en && !inflight && (occ == '0)) state <= IDLE;
          ERR:     state <= ERR;
          default: state <= ERR;
        endcase
      end
    end
  end

  fifo_stream_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .OCC_W (OCC_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (capture),
    .push_data (fifo_dout),
    .pop       (consume),
    .occ       (occ),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int WIDTH = 16;
  localparam int BUF_DEPTH = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic rd_en, fifo_wr_req, fifo_mt, fifo_err, fifo_rd_vld, out_rdy;
  logic [WIDTH-1:0] fifo_dout;
  logic fifo_rd, out_vld, busy, err;
  logic [WIDTH-1:0] out_data;
  logic fifo_rd_dp, out_vld_dp, busy_dp, err_dp;
  logic [WIDTH-1:0] out_data_dp;

  always #10 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .SINGLE_PORT(1'b1)) dut_sp (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .fifo_wr_req(fifo_wr_req),
    .fifo_mt(fifo_mt), .fifo_err(fifo_err), .fifo_rd_vld(fifo_rd_vld), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd), .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
    .busy(busy), .err(err));

  // Dual-port variant shares the inputs; only its issue logic is compared.
  fifo_stream_reader #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .SINGLE_PORT(1'b0)) dut_dp (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .fifo_wr_req(fifo_wr_req),
    .fifo_mt(fifo_mt), .fifo_err(fifo_err), .fifo_rd_vld(fifo_rd_vld), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd_dp), .out_vld(out_vld_dp), .out_data(out_data_dp), .out_rdy(out_rdy),
    .busy(busy_dp), .err(err_dp));

  int n_checks = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int cyc, n_rd, n_deliv, first_rd_cyc, mark;
  bit chk_timing, chk_sp, last_deliv_busy;

  typedef struct {
    logic rd_en;
    logic mt;
    logic wr_req;
    logic exp_rd_sp;
    logic exp_rd_dp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at settle time, clock edge, then the FIFO model answers.
  task automatic tick();
    logic fired;
    logic [WIDTH-1:0] w;
    #1;
    fired = fifo_rd;
    if (fired) begin
      if (n_rd == 0) first_rd_cyc = cyc;
      n_rd++;
    end
    if (chk_sp && fifo_wr_req) check("sp_wr_blocks_rd", fifo_rd, 0);
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_word: got 0x%0h expected no word", out_data);
      end else begin
        w = exp_q.pop_front();
        check("stream_data", out_data, w);
      end
      if (chk_timing) check("stream_cycle", cyc, first_rd_cyc + 2 + n_deliv);
      last_deliv_busy = busy;
      n_deliv++;
    end
    @(posedge clk);
    #1;
    cyc++;
    fifo_rd_vld = fired;
    fifo_dout = '0;
    if (fired) begin
      if (fifo_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_on_empty: got pop expected none");
      end else begin
        w = fifo_q.pop_front();
        fifo_dout = w;
        exp_q.push_back(w);
      end
    end
    fifo_mt = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic run_until_deliv(input int n, input int max_cyc, input bit toggle_wr);
    int k = 0;
    while (n_deliv < n && k < max_cyc) begin
      if (toggle_wr) fifo_wr_req = ~fifo_wr_req;
      tick();
      k++;
    end
    check("deliver_count", n_deliv, n);
  endtask

  task automatic preload(input int n);
    for (int i = 1; i <= n; i++) fifo_q.push_back(WIDTH'(i));
    fifo_mt = (fifo_q.size() == 0);
  endtask

  task automatic do_reset(input bit chk);
    rd_en = 0; out_rdy = 0; fifo_wr_req = 0; fifo_err = 0;
    fifo_rd_vld = 0; fifo_dout = '0; fifo_mt = 1;
    fifo_q.delete();
    exp_q.delete();
    cyc = 0; n_rd = 0; n_deliv = 0; first_rd_cyc = 0;
    chk_timing = 0; chk_sp = 0; last_deliv_busy = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_state", dut_sp.state, IDLE);
    end
    reset_n = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset values, then the issue equation in RUN with an empty buffer (no clock edges).
    do_reset(1);
    rd_en = 1;
    tick();
    check("run_entered", dut_sp.state, RUN);
    for (int i = 0; i < 6; i++) begin
      rd_en = vecs[i].rd_en;
      fifo_mt = vecs[i].mt;
      fifo_wr_req = vecs[i].wr_req;
      #1;
      check($sformatf("issue_sp_%0d", i), fifo_rd, vecs[i].exp_rd_sp);
      check($sformatf("issue_dp_%0d", i), fifo_rd_dp, vecs[i].exp_rd_dp);
    end
    rd_en = 0; fifo_mt = 1; fifo_wr_req = 0;

    // Streaming without backpressure.
    do_reset(0);
    preload(8);
    rd_en = 1; out_rdy = 1; chk_timing = 1;
    run_until_deliv(8, 40, 0);
    check("t1_busy_last_word", last_deliv_busy, 1);
    check("t1_busy_after", busy, 0);
    check("t1_n_rd", n_rd, 8);

    // Backpressure: credit limits outstanding pops to the buffer depth.
    do_reset(0);
    preload(10);
    rd_en = 1; out_rdy = 0;
    repeat (10) tick();
    check("t2_n_rd", n_rd, 3);
    check("t2_fifo_rd", fifo_rd, 0);
    check("t2_occ", dut_sp.occ, 3);
    check("t2_out_vld", out_vld, 1);
    check("t2_out_data_held", out_data, 16'h0001);
    out_rdy = 1;
    run_until_deliv(10, 60, 0);
    check("t2_fifo_drained", fifo_q.size(), 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // Single-port: writer requests on alternate cycles block pops.
    do_reset(0);
    preload(8);
    rd_en = 1; out_rdy = 1; chk_sp = 1;
    run_until_deliv(8, 80, 1);
    check("t3_sb_empty", exp_q.size(), 0);
    fifo_wr_req = 0; chk_sp = 0;

    // Empty boundary: a single word gives exactly one pop and one delivery.
    do_reset(0);
    preload(1);
    rd_en = 1; out_rdy = 1;
    repeat (8) tick();
    check("t4_n_rd", n_rd, 1);
    check("t4_n_deliv", n_deliv, 1);
    check("t4_fifo_rd", fifo_rd, 0);
    check("t4_busy", busy, 0);

    // Protocol error: read-valid without an outstanding pop.
    do_reset(0);
    preload(10);
    rd_en = 1; out_rdy = 0;
    repeat (6) tick();
    fifo_rd_vld = 1;
    tick();
    check("t5_err", err, 1);
    check("t5_state", dut_sp.state, ERR);
    mark = n_rd;
    out_rdy = 1;
    repeat (8) tick();
    check("t5_no_pops", n_rd, mark);
    check("t5_drained", n_deliv, 3);
    check("t5_err_sticky", err, 1);
    check("t5_out_vld", out_vld, 0);
    #2 reset_n = 0;
    #1 check("t5_err_cleared", err, 0);

    // FIFO error mid-stream: the pop already in flight still lands and drains.
    do_reset(0);
    preload(8);
    rd_en = 1; out_rdy = 1;
    repeat (4) tick();
    fifo_err = 1;
    tick();
    fifo_err = 0;
    check("t5b_err", err, 1);
    mark = n_rd;
    repeat (6) tick();
    check("t5b_no_pops", n_rd, mark);
    check("t5b_all_popped_delivered", n_deliv, n_rd);
    check("t5b_sb_empty", exp_q.size(), 0);
    check("t5b_busy", busy, 0);

    // rd_en dropped with two pops outstanding.
    do_reset(0);
    preload(10);
    rd_en = 1; out_rdy = 1;
    repeat (3) tick();
    rd_en = 0;
    run_until_deliv(2, 10, 0);
    check("t6_n_rd", n_rd, 2);
    check("t6_busy", busy, 0);
    tick();
    check("t6_idle", dut_sp.state, IDLE);
    check("t6_n_deliv", n_deliv, 2);

    // Asynchronous reset with two words buffered.
    do_reset(0);
    preload(10);
    rd_en = 1; out_rdy = 0;
    repeat (4) tick();
    check("t6b_occ", dut_sp.occ, 2);
    #2 reset_n = 0;
    #1;
    check("t6b_out_vld", out_vld, 0);
    check("t6b_err", err, 0);
    check("t6b_busy", busy, 0);
    check("t6b_fifo_rd", fifo_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
